// File: rtl/arcanoid_pkg.sv
// Shared constants and types for the arcanoid video chain.
package arcanoid_pkg;
  localparam int H_ACTIVE = 1024;
  localparam int V_ACTIVE = 768;
  localparam int RGB_W    = 12;
  localparam int BCD_W    = 4;

  localparam logic [RGB_W-1:0] BLACK        = 12'h000;
  localparam logic [RGB_W-1:0] SCORE_YELLOW = 12'hFF0;

  typedef struct packed {
    logic [10:0]      hcount;
    logic [10:0]      vcount;
    logic             hsync;
    logic             vsync;
    logic             hblnk;
    logic             vblnk;
    logic [RGB_W-1:0] rgb;
  } vid_t;
endpackage

// File: rtl/seg7_decode.sv
// BCD to seven-segment decode, output bits {a,b,c,d,e,f,g}; non-BCD codes go dark.
module seg7_decode
  import arcanoid_pkg::*;
(
  input  logic [BCD_W-1:0] bcd,
  output logic [6:0]       seg
);
  always_comb begin
    case (bcd)
      4'd0:    seg = 7'b1111110;
      4'd1:    seg = 7'b0110000;
      4'd2:    seg = 7'b1101101;
      4'd3:    seg = 7'b1111001;
      4'd4:    seg = 7'b0110011;
      4'd5:    seg = 7'b1011011;
      4'd6:    seg = 7'b1011111;
      4'd7:    seg = 7'b1110000;
      4'd8:    seg = 7'b1111111;
      4'd9:    seg = 7'b1111011;
      default: seg = 7'b0000000;
    endcase
  end
endmodule

// File: rtl/draw_score.sv
// Score overlay: 4-digit saturating BCD counter, per-frame display latch and a
// 2-stage pixel pipeline that paints seven-segment digits over the RGB stream.
module draw_score
  import arcanoid_pkg::*;
#(
  parameter int               XPOS    = 16,
  parameter int               YPOS    = 8,
  parameter int               DIG_W   = 24,
  parameter int               DIG_H   = 40,
  parameter int               DIG_GAP = 8,
  parameter int               SEG_W   = 4,
  parameter logic [RGB_W-1:0] COLOR   = SCORE_YELLOW
) (
  input  logic             pclk,
  input  logic             reset,
  input  logic [10:0]      hcount_in,
  input  logic [10:0]      vcount_in,
  input  logic             hsync_in,
  input  logic             vsync_in,
  input  logic             hblnk_in,
  input  logic             vblnk_in,
  input  logic [RGB_W-1:0] rgb_in,
  input  logic             score_inc,
  input  logic             score_clr,
  output logic [10:0]      hcount_out,
  output logic [10:0]      vcount_out,
  output logic             hsync_out,
  output logic             vsync_out,
  output logic             hblnk_out,
  output logic             vblnk_out,
  output logic [RGB_W-1:0] rgb_out,
  output logic [15:0]      score_bcd
);
  localparam int PITCH = DIG_W + DIG_GAP;
  localparam logic [10:0] X_LO  = 11'(XPOS);
  localparam logic [10:0] X_HI  = 11'(XPOS + 4*DIG_W + 3*DIG_GAP);
  localparam logic [10:0] Y_LO  = 11'(YPOS);
  localparam logic [10:0] Y_HI  = 11'(YPOS + DIG_H);
  localparam logic [10:0] P1    = 11'(PITCH);
  localparam logic [10:0] P2    = 11'(2*PITCH);
  localparam logic [10:0] P3    = 11'(3*PITCH);
  localparam logic [10:0] DW    = 11'(DIG_W);
  localparam logic [10:0] SW    = 11'(SEG_W);
  localparam logic [10:0] DW_SW = 11'(DIG_W - SEG_W);
  localparam logic [10:0] DH_SW = 11'(DIG_H - SEG_W);
  localparam logic [10:0] HALF  = 11'(DIG_H/2);
  localparam logic [10:0] G_LO  = 11'(DIG_H/2 - SEG_W/2);
  localparam logic [10:0] G_HI  = 11'(DIG_H/2 + SEG_W/2);

  function automatic logic [15:0] bcd_inc(input logic [15:0] v);
    logic [15:0] r;
    logic        carry;
    r     = v;
    carry = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (carry) begin
        if (v[4*i +: 4] == 4'd9) r[4*i +: 4] = 4'd0;
        else begin
          r[4*i +: 4] = v[4*i +: 4] + 4'd1;
          carry       = 1'b0;
        end
      end
    end
    return r;
  endfunction

  logic [15:0]      score_q, score_d, disp_q, disp_d;
  logic             vblnk_prev_q, vblnk_prev_d;
  vid_t             vid_p1_q, vid_p1_d, vid_p2_q, vid_p2_d;
  logic [10:0]      lx_p1_q, lx_p1_d, ly_p1_q, ly_p1_d;
  logic [BCD_W-1:0] digit_p1_q, digit_p1_d;
  logic             in_digit_p1_q, in_digit_p1_d;
  logic [10:0]      dx;
  logic [1:0]       k;
  logic [3:0]       zlead;
  logic             in_box, upper, lit;
  logic [6:0]       seg, seg_hit;

  always_comb begin
    score_d = score_q;
    if (score_clr) score_d = '0;
    else if (score_inc && score_q != 16'h9999) score_d = bcd_inc(score_q);
    vblnk_prev_d = vblnk_in;
    // Latch only on the blanking rising edge so a frame never shows two values.
    disp_d = (vblnk_in && !vblnk_prev_q) ? score_q : disp_q;
  end

  // Stage 1: box test, cell split and digit select
  always_comb begin
    vid_p1_d = '{hcount: hcount_in, vcount: vcount_in, hsync: hsync_in,
                 vsync: vsync_in, hblnk: hblnk_in, vblnk: vblnk_in, rgb: rgb_in};
    in_box = (hcount_in >= X_LO) && (hcount_in < X_HI) &&
             (vcount_in >= Y_LO) && (vcount_in < Y_HI);
    dx      = hcount_in - X_LO;
    ly_p1_d = vcount_in - Y_LO;
    // Only four cells, so comparing against pitch multiples replaces the divide.
    if (dx >= P3)      begin k = 2'd0; lx_p1_d = dx - P3; end
    else if (dx >= P2) begin k = 2'd1; lx_p1_d = dx - P2; end
    else if (dx >= P1) begin k = 2'd2; lx_p1_d = dx - P1; end
    else               begin k = 2'd3; lx_p1_d = dx;      end
    zlead[3] = (disp_q[15:12] == 4'd0);
    zlead[2] = zlead[3] && (disp_q[11:8] == 4'd0);
    zlead[1] = zlead[2] && (disp_q[7:4] == 4'd0);
    zlead[0] = 1'b0;
    digit_p1_d    = disp_q[{k, 2'b00} +: 4];
    in_digit_p1_d = in_box && (lx_p1_d < DW) && !zlead[k];
  end

  seg7_decode u_dec (
    .bcd (digit_p1_q),
    .seg (seg)
  );

  // Stage 2: segment hit test and compositing
  always_comb begin
    upper   = ly_p1_q < HALF;
    seg_hit = {ly_p1_q < SW,
               (lx_p1_q >= DW_SW) && upper,
               (lx_p1_q >= DW_SW) && !upper,
               ly_p1_q >= DH_SW,
               (lx_p1_q < SW) && !upper,
               (lx_p1_q < SW) && upper,
               (ly_p1_q >= G_LO) && (ly_p1_q < G_HI)};
    lit      = in_digit_p1_q && |(seg & seg_hit);
    vid_p2_d = vid_p1_q;
    if (vid_p1_q.hblnk || vid_p1_q.vblnk) vid_p2_d.rgb = BLACK;
    else if (lit)                         vid_p2_d.rgb = COLOR;
  end

  always_ff @(posedge pclk or negedge reset) begin
    if (!reset) begin
      score_q       <= '0;
      disp_q        <= '0;
      vblnk_prev_q  <= 1'b0;
      vid_p1_q      <= '0;
      lx_p1_q       <= '0;
      ly_p1_q       <= '0;
      digit_p1_q    <= '0;
      in_digit_p1_q <= 1'b0;
      vid_p2_q      <= '0;
    end else begin
      score_q       <= score_d;
      disp_q        <= disp_d;
      vblnk_prev_q  <= vblnk_prev_d;
      vid_p1_q      <= vid_p1_d;
      lx_p1_q       <= lx_p1_d;
      ly_p1_q       <= ly_p1_d;
      digit_p1_q    <= digit_p1_d;
      in_digit_p1_q <= in_digit_p1_d;
      vid_p2_q      <= vid_p2_d;
    end
  end

  assign hcount_out = vid_p2_q.hcount;
  assign vcount_out = vid_p2_q.vcount;
  assign hsync_out  = vid_p2_q.hsync;
  assign vsync_out  = vid_p2_q.vsync;
  assign hblnk_out  = vid_p2_q.hblnk;
  assign vblnk_out  = vid_p2_q.vblnk;
  assign rgb_out    = vid_p2_q.rgb;
  assign score_bcd  = score_q;
endmodule

// File: tb/tb_draw_score.sv
// Bench for draw_score: reduced-size frames and random pixels against a
// behavioural model of score counting, frame latching and glyph drawing.
module tb_draw_score;
  localparam int X0 = 16, Y0 = 8, DW = 24, DH = 40, GAP = 8, SW = 4;
  localparam logic [11:0] COL = 12'hFF0;
  localparam int H_TOT = 150, H_ACT = 140, V_TOT = 50, V_ACT = 48;
  localparam int FRAME = H_TOT * V_TOT;

  logic        pclk = 1'b0;
  logic        reset = 1'b1;
  logic [10:0] hcount_in = '0, vcount_in = '0;
  logic        hsync_in = 0, vsync_in = 0, hblnk_in = 0, vblnk_in = 0;
  logic [11:0] rgb_in = '0;
  logic        score_inc = 0, score_clr = 0;
  logic [10:0] hcount_out, vcount_out;
  logic        hsync_out, vsync_out, hblnk_out, vblnk_out;
  logic [11:0] rgb_out;
  logic [15:0] score_bcd;

  draw_score dut (
    .pclk(pclk), .reset(reset),
    .hcount_in(hcount_in), .vcount_in(vcount_in),
    .hsync_in(hsync_in), .vsync_in(vsync_in), .hblnk_in(hblnk_in), .vblnk_in(vblnk_in),
    .rgb_in(rgb_in), .score_inc(score_inc), .score_clr(score_clr),
    .hcount_out(hcount_out), .vcount_out(vcount_out),
    .hsync_out(hsync_out), .vsync_out(vsync_out), .hblnk_out(hblnk_out), .vblnk_out(vblnk_out),
    .rgb_out(rgb_out), .score_bcd(score_bcd)
  );

  always #5 pclk = ~pclk;

  typedef struct {
    logic [10:0] h, v;
    logic        hs, vs, hb, vb;
    logic [11:0] rgb;
  } pix_t;

  pix_t  q[$];
  int    cmp_cnt = 0, fail_cnt = 0;
  int    m_score, m_disp;
  bit    m_vb_prev;
  int    px_bad, sc_bad, n_col, n_zero, n_other;
  string first_bad;
  string SEGS[10] = '{"abcdef", "bc", "abdeg", "abcdg", "bcfg",
                      "acdfg", "acdefg", "abc", "abcdefg", "abcdfg"};

  function automatic logic [11:0] exp_rgb(input int h, input int v, input bit hb, input bit vb,
                                          input logic [11:0] rin, input int disp);
    int dx, lx, ly, k, pw, dig;
    bit hit, upper;
    string s;
    if (hb || vb) return 12'h000;
    if (h < X0 || h >= X0 + 4*DW + 3*GAP || v < Y0 || v >= Y0 + DH) return rin;
    dx = h - X0;
    k  = 3 - dx / (DW + GAP);
    lx = dx % (DW + GAP);
    ly = v - Y0;
    if (lx >= DW) return rin;
    pw = 1;
    for (int j = 0; j < k; j++) pw = pw * 10;
    if (k > 0 && disp < pw) return rin;
    dig   = (disp / pw) % 10;
    s     = SEGS[dig];
    upper = ly < DH/2;
    hit   = 0;
    for (int i = 0; i < s.len(); i++) begin
      case (s[i])
        "a": hit |= (ly < SW);
        "b": hit |= (lx >= DW - SW) && upper;
        "c": hit |= (lx >= DW - SW) && !upper;
        "d": hit |= (ly >= DH - SW);
        "e": hit |= (lx < SW) && !upper;
        "f": hit |= (lx < SW) && upper;
        "g": hit |= (ly >= DH/2 - SW/2) && (ly < DH/2 + SW/2);
        default: ;
      endcase
    end
    return hit ? COL : rin;
  endfunction

  function automatic logic [15:0] to_bcd(input int n);
    return {4'(n / 1000), 4'((n / 100) % 10), 4'((n / 10) % 10), 4'(n % 10)};
  endfunction

  task automatic model_reset();
    pix_t z;
    z.h = '0; z.v = '0; z.hs = 0; z.vs = 0; z.hb = 0; z.vb = 0; z.rgb = '0;
    m_score = 0; m_disp = 0; m_vb_prev = 0;
    q.delete();
    q.push_back(z);
  endtask

  task automatic clear_tally();
    px_bad = 0; sc_bad = 0; n_col = 0; n_zero = 0; n_other = 0; first_bad = "none";
  endtask

  task automatic drive(input logic [10:0] h, input logic [10:0] v, input logic hs, input logic vs,
                       input logic hb, input logic vb, input logic [11:0] rgb,
                       input logic inc, input logic clr);
    pix_t e, o;
    @(negedge pclk);
    hcount_in = h; vcount_in = v; hsync_in = hs; vsync_in = vs;
    hblnk_in = hb; vblnk_in = vb; rgb_in = rgb; score_inc = inc; score_clr = clr;
    e.h = h; e.v = v; e.hs = hs; e.vs = vs; e.hb = hb; e.vb = vb;
    e.rgb = exp_rgb(int'(h), int'(v), hb, vb, rgb, m_disp);
    q.push_back(e);
    @(posedge pclk);
    if (vb && !m_vb_prev) m_disp = m_score;
    m_vb_prev = vb;
    if (clr) m_score = 0;
    else if (inc && m_score < 9999) m_score++;
    #1;
    o = q.pop_front();
    if ({hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out, rgb_out} !==
        {o.h, o.v, o.hs, o.vs, o.hb, o.vb, o.rgb}) begin
      if (px_bad == 0)
        first_bad = $sformatf("got h=%0d v=%0d s/b=%b%b%b%b rgb=%h, want h=%0d v=%0d s/b=%b%b%b%b rgb=%h",
                              hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out, rgb_out,
                              o.h, o.v, o.hs, o.vs, o.hb, o.vb, o.rgb);
      px_bad++;
    end
    if (score_bcd !== to_bcd(m_score)) sc_bad++;
    if (rgb_out === COL) n_col++;
    else if (rgb_out === 12'h000) n_zero++;
    else n_other++;
  endtask

  task automatic run_span(input int p0, input int n, input bit inc, input bit clr, input int fix);
    for (int i = 0; i < n; i++) begin
      int p, h, v;
      logic [11:0] c;
      p = p0 + i;
      h = p % H_TOT;
      v = (p / H_TOT) % V_TOT;
      if (fix >= 0) c = 12'(fix);
      else begin
        c = 12'($urandom);
        if (c == COL) c = 12'h0F0;
      end
      drive(11'(h), 11'(v), h >= 142 && h < 146, v == V_TOT - 1, h >= H_ACT, v >= V_ACT, c, inc, clr);
    end
  endtask

  task automatic test_reset();
    #2 reset = 1'b0;
    model_reset();
    repeat (3) @(posedge pclk);
    #1;
    cmp_cnt++; if (rgb_out !== 12'h000) begin fail_cnt++; $display("FAIL reset_rgb: got %h want 000", rgb_out); end
    cmp_cnt++; if (score_bcd !== 16'h0000) begin fail_cnt++; $display("FAIL reset_bcd: got %h want 0000", score_bcd); end
    cmp_cnt++; if ({hcount_out, vcount_out} !== 22'd0) begin fail_cnt++; $display("FAIL reset_counts: got %0d/%0d want 0/0", hcount_out, vcount_out); end
    cmp_cnt++; if ({hsync_out, vsync_out, hblnk_out, vblnk_out} !== 4'b0000) begin fail_cnt++;
      $display("FAIL reset_sync: got %b%b%b%b want 0000", hsync_out, vsync_out, hblnk_out, vblnk_out); end
    @(posedge pclk);
    #1 reset = 1'b1;
  endtask

  task automatic test_frame_zero();
    clear_tally();
    run_span(0, FRAME, 0, 0, 12'h00F);
    cmp_cnt++; if (px_bad !== 0) begin fail_cnt++; $display("FAIL zero_frame_px: %0d bad pixels, first %s", px_bad, first_bad); end
    cmp_cnt++; if (n_col !== 448) begin fail_cnt++; $display("FAIL zero_frame_glyph: got %0d glyph px want 448", n_col); end
    cmp_cnt++; if (n_zero !== 780) begin fail_cnt++; $display("FAIL zero_frame_blank: got %0d black px want 780", n_zero); end
    cmp_cnt++; if (n_other !== 6272) begin fail_cnt++; $display("FAIL zero_frame_bg: got %0d bg px want 6272", n_other); end
  endtask

  task automatic test_inc_123();
    clear_tally();
    run_span(0, 10*H_TOT, 0, 0, -1);
    run_span(10*H_TOT, 123, 1, 0, -1);
    cmp_cnt++; if (score_bcd !== 16'h0123) begin fail_cnt++; $display("FAIL inc123_bcd: got %h want 0123", score_bcd); end
    run_span(10*H_TOT + 123, FRAME - 10*H_TOT - 123, 0, 0, -1);
    cmp_cnt++; if (n_col !== 448) begin fail_cnt++; $display("FAIL inc123_same_frame: got %0d glyph px want 448", n_col); end
    cmp_cnt++; if (px_bad !== 0) begin fail_cnt++; $display("FAIL inc123_px_a: %0d bad pixels, first %s", px_bad, first_bad); end
    clear_tally();
    run_span(0, FRAME, 0, 0, -1);
    cmp_cnt++; if (n_col !== 960) begin fail_cnt++; $display("FAIL inc123_next_frame: got %0d glyph px want 960", n_col); end
    cmp_cnt++; if (px_bad !== 0) begin fail_cnt++; $display("FAIL inc123_px_b: %0d bad pixels, first %s", px_bad, first_bad); end
    cmp_cnt++; if (sc_bad !== 0) begin fail_cnt++; $display("FAIL inc123_track: %0d bcd cycles off, want 0", sc_bad); end
  endtask

  task automatic test_saturate();
    clear_tally();
    run_span(0, 1, 0, 1, -1);
    run_span(1, 9999, 1, 0, -1);
    cmp_cnt++; if (score_bcd !== 16'h9999) begin fail_cnt++; $display("FAIL sat_reach: got %h want 9999", score_bcd); end
    run_span(10000, 2, 1, 0, -1);
    cmp_cnt++; if (score_bcd !== 16'h9999) begin fail_cnt++; $display("FAIL sat_hold: got %h want 9999", score_bcd); end
    cmp_cnt++; if (sc_bad !== 0) begin fail_cnt++; $display("FAIL sat_track: %0d bcd cycles off, want 0", sc_bad); end
  endtask

  task automatic test_clr_inc();
    run_span(0, 1, 0, 1, -1);
    run_span(1, 42, 1, 0, -1);
    cmp_cnt++; if (score_bcd !== 16'h0042) begin fail_cnt++; $display("FAIL clr_pre: got %h want 0042", score_bcd); end
    run_span(43, 1, 1, 1, -1);
    cmp_cnt++; if (score_bcd !== 16'h0000) begin fail_cnt++; $display("FAIL clr_wins: got %h want 0000", score_bcd); end
    run_span(44, 1, 1, 0, -1);
    cmp_cnt++; if (score_bcd !== 16'h0001) begin fail_cnt++; $display("FAIL clr_then_inc: got %h want 0001", score_bcd); end
  endtask

  task automatic test_random_pixels();
    clear_tally();
    for (int i = 0; i < 3000; i++) begin
      logic [10:0] h, v;
      if ($urandom_range(0, 1) == 0) begin
        h = 11'($urandom_range(0, 159));
        v = 11'($urandom_range(0, 59));
      end else begin
        h = 11'($urandom);
        v = 11'($urandom);
      end
      drive(h, v, 1'($urandom), 1'($urandom), $urandom_range(0, 7) == 0, $urandom_range(0, 15) == 0,
            12'($urandom), $urandom_range(0, 3) == 0, $urandom_range(0, 127) == 0);
    end
    cmp_cnt++; if (px_bad !== 0) begin fail_cnt++; $display("FAIL random_px: %0d bad pixels, first %s", px_bad, first_bad); end
    cmp_cnt++; if (sc_bad !== 0) begin fail_cnt++; $display("FAIL random_bcd: %0d bcd cycles off, want 0", sc_bad); end
  endtask

  task automatic test_reset_midline();
    run_span(0, 1, 0, 1, -1);
    run_span(1, 57, 1, 0, -1);
    cmp_cnt++; if (score_bcd !== 16'h0057) begin fail_cnt++; $display("FAIL rst_pre: got %h want 0057", score_bcd); end
    run_span(58, 20*H_TOT + 70 - 58, 0, 0, -1);
    #2 reset = 1'b0;
    #1;
    cmp_cnt++; if (rgb_out !== 12'h000) begin fail_cnt++; $display("FAIL rst_async_rgb: got %h want 000", rgb_out); end
    cmp_cnt++; if ({hcount_out, vcount_out} !== 22'd0) begin fail_cnt++; $display("FAIL rst_async_counts: got %0d/%0d want 0/0", hcount_out, vcount_out); end
    cmp_cnt++; if ({hsync_out, vsync_out, hblnk_out, vblnk_out} !== 4'b0000) begin fail_cnt++;
      $display("FAIL rst_async_sync: got %b%b%b%b want 0000", hsync_out, vsync_out, hblnk_out, vblnk_out); end
    cmp_cnt++; if (score_bcd !== 16'h0000) begin fail_cnt++; $display("FAIL rst_async_bcd: got %h want 0000", score_bcd); end
    model_reset();
    repeat (2) @(posedge pclk);
    #1 reset = 1'b1;
    clear_tally();
    run_span(0, FRAME, 0, 0, -1);
    cmp_cnt++; if (score_bcd !== 16'h0000) begin fail_cnt++; $display("FAIL rst_after_bcd: got %h want 0000", score_bcd); end
    cmp_cnt++; if (n_col !== 448) begin fail_cnt++; $display("FAIL rst_after_glyph: got %0d glyph px want 448", n_col); end
    cmp_cnt++; if (px_bad !== 0) begin fail_cnt++; $display("FAIL rst_after_px: %0d bad pixels, first %s", px_bad, first_bad); end
  endtask

  initial begin
    test_reset();
    test_frame_zero();
    test_inc_123();
    test_saturate();
    test_clr_inc();
    test_random_pixels();
    test_reset_midline();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, fail_cnt);
    $finish;
  end
endmodule
